// File: rtl/l2cache_dv_array_if.sv
// Access/flush bus of the L2 dirty/valid status array.
//   master: L2 controller (drives ena/wea/addra/dina/flush_req/flush_mask)
//   slave : l2cache_dv_array (drives douta/dout_vld/ready/flush_done)
// addra = {set index, way select}; douta holds way w at [w*DV_W +: DV_W].
interface l2cache_dv_array_if #(
  parameter int WAYS = 8,
  parameter int SETS = 128,
  parameter int DV_W = 2
) ();
  localparam int SW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);

  logic                 ena;
  logic                 wea;
  logic [SW+WW-1:0]     addra;
  logic [DV_W-1:0]      dina;
  logic [WAYS*DV_W-1:0] douta;
  logic                 dout_vld;
  logic                 ready;
  logic                 flush_req;
  logic [DV_W-1:0]      flush_mask;
  logic                 flush_done;

  modport master (
    output ena, wea, addra, dina, flush_req, flush_mask,
    input  douta, dout_vld, ready, flush_done
  );

  modport slave (
    input  ena, wea, addra, dina, flush_req, flush_mask,
    output douta, dout_vld, ready, flush_done
  );
endinterface

// File: rtl/l2cache_dv_array.sv
// Dirty/valid status array for the L2 cache: WAYS x SETS x DV_W bits,
// single-ported, registered read data.
//   clka : clock, rising edge
//   rsta : synchronous active-high reset
//   bus  : slave side of l2cache_dv_array_if
//          reads return a whole set, writes update one way (write-first),
//          flush_req starts a sweep clearing flush_mask bits in every way.
// After reset an init sweep zeroes every set before ready rises.
module l2cache_dv_array #(
  parameter int WAYS = 8,
  parameter int SETS = 128,
  parameter int DV_W = 2
) (
  input  logic              clka,
  input  logic              rsta,
  l2cache_dv_array_if.slave bus
);
  localparam int SW    = $clog2(SETS);
  localparam int WW    = $clog2(WAYS);
  localparam int ROW_W = WAYS * DV_W;
  localparam logic [SW-1:0] LAST_SET = SW'(SETS - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_FLUSH} state_t;

  logic [ROW_W-1:0] mem [SETS];

  state_t           state_reg, state_next;
  logic [SW-1:0]    cnt_reg, cnt_next;
  logic [DV_W-1:0]  mask_reg, mask_next;
  logic [ROW_W-1:0] douta_reg, douta_next;
  logic             dout_vld_reg, dout_vld_next;
  logic             ready_reg, ready_next;
  logic             flush_done_reg, flush_done_next;

  logic [SW-1:0]    set_idx;
  logic [WW-1:0]    way_idx;
  logic [SW-1:0]    arr_addr;
  logic [ROW_W-1:0] row_rd;
  logic [ROW_W-1:0] row_merged;
  logic [ROW_W-1:0] row_cleared;
  logic [ROW_W-1:0] arr_wdata;
  logic             arr_we;

  assign set_idx = bus.addra[SW+WW-1:WW];
  assign way_idx = bus.addra[WW-1:0];

  // The single port serves the access set in IDLE and the sweep counter otherwise.
  assign arr_addr = (state_reg == S_IDLE) ? set_idx : cnt_reg;
  assign row_rd   = mem[arr_addr];

  // Per-way merge for writes and per-way mask clear for flash sweeps.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign row_merged[gi*DV_W +: DV_W] =
        (way_idx == WW'(gi)) ? bus.dina : row_rd[gi*DV_W +: DV_W];
      assign row_cleared[gi*DV_W +: DV_W] = row_rd[gi*DV_W +: DV_W] & ~mask_reg;
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    mask_next       = mask_reg;
    douta_next      = douta_reg;
    dout_vld_next   = 1'b0;
    flush_done_next = 1'b0;
    arr_we          = 1'b0;
    arr_wdata       = row_rd;
    case (state_reg)
      S_INIT: begin
        arr_we    = 1'b1;
        arr_wdata = '0;
        if (cnt_reg == LAST_SET) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + SW'(1);
        end
      end
      S_IDLE: begin
        if (bus.ena) begin
          dout_vld_next = 1'b1;
          if (bus.wea) begin
            arr_we     = 1'b1;
            arr_wdata  = row_merged;
            douta_next = row_merged;
          end else begin
            douta_next = row_rd;
          end
        end
        // A same-cycle access lands first; the sweep starts at set 0 afterwards.
        if (bus.flush_req) begin
          mask_next  = bus.flush_mask;
          state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        arr_we    = 1'b1;
        arr_wdata = row_cleared;
        if (cnt_reg == LAST_SET) begin
          state_next      = S_IDLE;
          cnt_next        = '0;
          flush_done_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + SW'(1);
        end
      end
      default: begin
        state_next = S_INIT;
        cnt_next   = '0;
      end
    endcase
    ready_next = (state_next == S_IDLE);
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_reg      <= S_INIT;
      cnt_reg        <= '0;
      mask_reg       <= '0;
      douta_reg      <= '0;
      dout_vld_reg   <= 1'b0;
      ready_reg      <= 1'b0;
      flush_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      mask_reg       <= mask_next;
      douta_reg      <= douta_next;
      dout_vld_reg   <= dout_vld_next;
      ready_reg      <= ready_next;
      flush_done_reg <= flush_done_next;
    end
  end

  // Array contents are left untouched while reset is asserted.
  always_ff @(posedge clka) begin
    if (arr_we && !rsta) begin
      mem[arr_addr] <= arr_wdata;
    end
  end

  assign bus.douta      = douta_reg;
  assign bus.dout_vld   = dout_vld_reg;
  assign bus.ready      = ready_reg;
  assign bus.flush_done = flush_done_reg;
endmodule

// File: tb/tb_l2cache_dv_array.sv
// Directed bench for l2cache_dv_array: default 8x128x2 instance plus a
// 2-way/4-set/3-bit instance for the boundary case.
module tb_l2cache_dv_array;
  logic clk  = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  l2cache_dv_array_if #(.WAYS(8), .SETS(128), .DV_W(2)) bus0 ();
  l2cache_dv_array_if #(.WAYS(2), .SETS(4),   .DV_W(3)) bus1 ();

  l2cache_dv_array #(.WAYS(8), .SETS(128), .DV_W(2)) d0 (.clka(clk), .rsta(rst0), .bus(bus0));
  l2cache_dv_array #(.WAYS(2), .SETS(4),   .DV_W(3)) d1 (.clka(clk), .rsta(rst1), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on d0; on return the response of the accepted edge is visible.
  task automatic acc0(input logic we, input int set, input int way, input logic [1:0] din);
    bus0.ena   = 1'b1;
    bus0.wea   = we;
    bus0.addra = 10'(set * 8 + way);
    bus0.dina  = din;
    tick();
    bus0.ena = 1'b0;
    bus0.wea = 1'b0;
    $display("d0 %s set=%0d way=%0d din=%b -> douta=%h vld=%b ready=%b",
             we ? "WR" : "RD", set, way, din, bus0.douta, bus0.dout_vld, bus0.ready);
  endtask

  task automatic acc1(input logic we, input int set, input int way, input logic [2:0] din);
    bus1.ena   = 1'b1;
    bus1.wea   = we;
    bus1.addra = 3'(set * 2 + way);
    bus1.dina  = din;
    tick();
    bus1.ena = 1'b0;
    bus1.wea = 1'b0;
    $display("d1 %s set=%0d way=%0d din=%b -> douta=%b vld=%b",
             we ? "WR" : "RD", set, way, din, bus1.douta, bus1.dout_vld);
  endtask

  task automatic test_reset();
    int n;
    int sets[3] = '{0, 64, 127};
    rst0 = 1'b1;
    repeat (3) tick();
    vectors++;
    if (bus0.ready !== 1'b0 || bus0.dout_vld !== 1'b0 || bus0.douta !== 16'h0 || bus0.flush_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs ready=%b vld=%b douta=%h done=%b expected 0/0/0000/0",
               bus0.ready, bus0.dout_vld, bus0.douta, bus0.flush_done);
    end
    rst0 = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus0.ready !== 1'b1 && n < 1000);
    $display("init: ready rose after %0d cycles", n);
    vectors++;
    if (n !== 128) begin
      miscompares++;
      $display("FAIL init_length got %0d expected 128", n);
    end
    foreach (sets[i]) begin
      acc0(1'b0, sets[i], 0, 2'b00);
      vectors++;
      if (bus0.douta !== 16'h0000 || bus0.dout_vld !== 1'b1) begin
        miscompares++;
        $display("FAIL init_read set %0d douta=%h vld=%b expected 0000/1", sets[i], bus0.douta, bus0.dout_vld);
      end
    end
  endtask

  task automatic test_write_read();
    acc0(1'b1, 5, 3, 2'b11);
    vectors++;
    if (bus0.douta !== 16'h00C0 || bus0.dout_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_resp1 douta=%h vld=%b expected 00c0/1", bus0.douta, bus0.dout_vld);
    end
    acc0(1'b1, 5, 0, 2'b01);
    vectors++;
    if (bus0.douta !== 16'h00C1) begin
      miscompares++;
      $display("FAIL wr_resp2 douta=%h expected 00c1", bus0.douta);
    end
    tick();
    vectors++;
    if (bus0.dout_vld !== 1'b0 || bus0.douta !== 16'h00C1) begin
      miscompares++;
      $display("FAIL idle_hold vld=%b douta=%h expected 0/00c1", bus0.dout_vld, bus0.douta);
    end
    acc0(1'b0, 5, 0, 2'b00);
    vectors++;
    if (bus0.douta !== 16'h00C1 || bus0.dout_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_set5 douta=%h vld=%b expected 00c1/1", bus0.douta, bus0.dout_vld);
    end
    tick();
    vectors++;
    if (bus0.dout_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL vld_one_cycle vld=%b expected 0", bus0.dout_vld);
    end
    acc0(1'b0, 4, 0, 2'b00);
    vectors++;
    if (bus0.douta !== 16'h0000) begin
      miscompares++;
      $display("FAIL rd_set4 douta=%h expected 0000", bus0.douta);
    end
    acc0(1'b0, 6, 0, 2'b00);
    vectors++;
    if (bus0.douta !== 16'h0000) begin
      miscompares++;
      $display("FAIL rd_set6 douta=%h expected 0000", bus0.douta);
    end
  endtask

  task automatic test_back_to_back();
    acc0(1'b1, 33, 7, 2'b10);
    vectors++;
    if (bus0.douta !== 16'h8000) begin
      miscompares++;
      $display("FAIL b2b_wr douta=%h expected 8000", bus0.douta);
    end
    acc0(1'b0, 33, 0, 2'b00);
    vectors++;
    if (bus0.douta !== 16'h8000 || bus0.dout_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_rd douta=%h vld=%b expected 8000/1", bus0.douta, bus0.dout_vld);
    end
    acc0(1'b0, 34, 0, 2'b00);
    vectors++;
    if (bus0.douta !== 16'h0000 || bus0.dout_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_rd2 douta=%h vld=%b expected 0000/1", bus0.douta, bus0.dout_vld);
    end
  endtask

  task automatic test_clean_flush();
    int n;
    int bad;
    for (int s = 0; s < 128; s++)
      for (int w = 0; w < 8; w++)
        acc0(1'b1, s, w, 2'b11);
    bus0.flush_req  = 1'b1;
    bus0.flush_mask = 2'b10;
    tick();
    bus0.flush_req  = 1'b0;
    bus0.flush_mask = 2'b00;
    n = 0;
    while (bus0.ready !== 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    $display("clean flush: ready low for %0d cycles, flush_done=%b", n, bus0.flush_done);
    vectors++;
    if (n !== 128) begin
      miscompares++;
      $display("FAIL flush_length got %0d expected 128", n);
    end
    vectors++;
    if (bus0.flush_done !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_done_pulse got %b expected 1", bus0.flush_done);
    end
    tick();
    vectors++;
    if (bus0.flush_done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_done_width got %b expected 0", bus0.flush_done);
    end
    bad = 0;
    for (int s = 0; s < 128; s++) begin
      acc0(1'b0, s, 0, 2'b00);
      if (bus0.douta !== 16'h5555) begin
        bad++;
        $display("FAIL clean_read set %0d douta=%h expected 5555", s, bus0.douta);
      end
    end
    vectors++;
    if (bad != 0) miscompares++;
  endtask

  task automatic test_access_during_sweep();
    int n;
    bus0.flush_req  = 1'b1;
    bus0.flush_mask = 2'b11;
    tick();
    bus0.flush_req = 1'b0;
    repeat (9) tick();
    acc0(1'b1, 9, 0, 2'b11);
    vectors++;
    if (bus0.dout_vld !== 1'b0 || bus0.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_drop vld=%b ready=%b expected 0/0", bus0.dout_vld, bus0.ready);
    end
    n = 0;
    while (bus0.flush_done !== 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    vectors++;
    if (bus0.flush_done !== 1'b1 || bus0.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL sweep_end done=%b ready=%b expected 1/1", bus0.flush_done, bus0.ready);
    end
    acc0(1'b0, 9, 0, 2'b00);
    vectors++;
    if (bus0.douta !== 16'h0000) begin
      miscompares++;
      $display("FAIL sweep_set9 douta=%h expected 0000", bus0.douta);
    end
    acc0(1'b0, 100, 0, 2'b00);
    vectors++;
    if (bus0.douta !== 16'h0000) begin
      miscompares++;
      $display("FAIL sweep_set100 douta=%h expected 0000", bus0.douta);
    end
  endtask

  task automatic test_reset_mid_flush();
    int n;
    int done_seen;
    int sets[3] = '{0, 20, 127};
    acc0(1'b1, 20, 2, 2'b01);
    vectors++;
    if (bus0.douta !== 16'h0010) begin
      miscompares++;
      $display("FAIL pre_wr douta=%h expected 0010", bus0.douta);
    end
    bus0.flush_req  = 1'b1;
    bus0.flush_mask = 2'b10;
    tick();
    bus0.flush_req = 1'b0;
    done_seen = 0;
    repeat (49) begin
      tick();
      if (bus0.flush_done === 1'b1) done_seen++;
    end
    rst0 = 1'b1;
    repeat (2) begin
      tick();
      if (bus0.flush_done === 1'b1) done_seen++;
    end
    vectors++;
    if (bus0.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_ready got %b expected 0", bus0.ready);
    end
    rst0 = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (bus0.flush_done === 1'b1) done_seen++;
    end while (bus0.ready !== 1'b1 && n < 1000);
    $display("reset mid-flush: ready rose after %0d cycles", n);
    vectors++;
    if (n !== 128) begin
      miscompares++;
      $display("FAIL midrst_init_length got %0d expected 128", n);
    end
    vectors++;
    if (done_seen !== 0) begin
      miscompares++;
      $display("FAIL midrst_no_done got %0d pulses expected 0", done_seen);
    end
    foreach (sets[i]) begin
      acc0(1'b0, sets[i], 0, 2'b00);
      vectors++;
      if (bus0.douta !== 16'h0000) begin
        miscompares++;
        $display("FAIL midrst_read set %0d douta=%h expected 0000", sets[i], bus0.douta);
      end
    end
  endtask

  task automatic test_boundary();
    int n;
    rst1 = 1'b1;
    repeat (2) tick();
    rst1 = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus1.ready !== 1'b1 && n < 100);
    $display("d1 init: ready rose after %0d cycles", n);
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL d1_init_length got %0d expected 4", n);
    end
    acc1(1'b1, 3, 1, 3'b101);
    vectors++;
    if (bus1.douta !== 6'b101000) begin
      miscompares++;
      $display("FAIL d1_wr douta=%b expected 101000", bus1.douta);
    end
    acc1(1'b0, 3, 0, 3'b000);
    vectors++;
    if (bus1.douta !== 6'b101000 || bus1.dout_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL d1_rd douta=%b vld=%b expected 101000/1", bus1.douta, bus1.dout_vld);
    end
    acc1(1'b0, 2, 0, 3'b000);
    vectors++;
    if (bus1.douta !== 6'b000000) begin
      miscompares++;
      $display("FAIL d1_rd_set2 douta=%b expected 000000", bus1.douta);
    end
  endtask

  initial begin
    bus0.ena = 1'b0; bus0.wea = 1'b0; bus0.addra = '0; bus0.dina = '0;
    bus0.flush_req = 1'b0; bus0.flush_mask = '0;
    bus1.ena = 1'b0; bus1.wea = 1'b0; bus1.addra = '0; bus1.dina = '0;
    bus1.flush_req = 1'b0; bus1.flush_mask = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_clean_flush();
    test_access_during_sweep();
    test_reset_mid_flush();
    test_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
